// File: rtl/mfp_uart_transmitter_pkg.sv
// mfp_uart_transmitter_pkg: frame constants and TX state encoding shared by the UART transmitter.
// Rev 1.0
`default_nettype none

package mfp_uart_transmitter_pkg;

  localparam int MFP_UART_DATA_BITS = 8;
  localparam int MFP_UART_STOP_BITS = 1;

  typedef enum logic [1:0] {
    MFP_UART_IDLE  = 2'd0,
    MFP_UART_START = 2'd1,
    MFP_UART_DATA  = 2'd2,
    MFP_UART_STOP  = 2'd3
  } mfp_uart_state_t;

endpackage

`default_nettype wire

// File: rtl/mfp_uart_tx_fifo.sv
// mfp_uart_tx_fifo: circular-buffer FIFO with registered ready/empty/count flags.
// Rev 1.0
`default_nettype none

module mfp_uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_req,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     ready,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   count_next
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;

  // ready is registered, so a pop at full never frees space for a same-cycle push
  assign push    = push_req && ready;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ready  <= 1'b1;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      ready <= (count_next != CW'(DEPTH));
      empty <= (count_next == '0);
    end
  end

endmodule

`default_nettype wire

// File: rtl/mfp_uart_transmitter.sv
// mfp_uart_transmitter: 8N1 LSB-first UART transmitter fed by a small byte FIFO.
// Rev 1.0
`default_nettype none

module mfp_uart_transmitter
  import mfp_uart_transmitter_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 50_000_000,
  parameter int BAUD_RATE       = 115200,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic                          HCLK,
  input  logic                          HRESETn,
  input  logic [7:0]                    byte_data,
  input  logic                          byte_valid,
  output logic                          byte_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int CLKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int BW           = $clog2(CLKS_PER_BIT);
  localparam int CW           = $clog2(FIFO_DEPTH) + 1;

  mfp_uart_state_t      state;
  logic [BW-1:0]        baud_cnt;
  logic [2:0]           bit_idx;
  logic [7:0]           shift;
  logic                 baud_last;
  logic                 pop;
  logic                 frame_next;
  logic                 fifo_empty;
  logic [7:0]           fifo_rd_data;
  logic [CW-1:0]        fifo_count_next;

  mfp_uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk        (HCLK),
    .rst_n      (HRESETn),
    .push_req   (byte_valid),
    .wr_data    (byte_data),
    .pop        (pop),
    .rd_data    (fifo_rd_data),
    .ready      (byte_ready),
    .empty      (fifo_empty),
    .count      (fifo_count),
    .count_next (fifo_count_next)
  );

  assign baud_last = (baud_cnt == BW'(CLKS_PER_BIT - 1));

  // Popping at the last stop cycle chains the next start bit with no idle gap
  assign pop = !fifo_empty &&
               ((state == MFP_UART_IDLE) || (state == MFP_UART_STOP && baud_last));

  assign frame_next = pop ||
                      ((state != MFP_UART_IDLE) && !(state == MFP_UART_STOP && baud_last));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= MFP_UART_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      overflow <= byte_valid && !byte_ready;
      busy     <= frame_next || (fifo_count_next != '0);
      case (state)
        MFP_UART_IDLE: begin
          tx       <= 1'b1;
          baud_cnt <= '0;
          if (pop) begin
            shift <= fifo_rd_data;
            tx    <= 1'b0;
            state <= MFP_UART_START;
          end
        end
        MFP_UART_START: begin
          if (baud_last) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= shift[0];
            state    <= MFP_UART_DATA;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        MFP_UART_DATA: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_idx == 3'(MFP_UART_DATA_BITS - 1)) begin
              tx    <= 1'b1;
              state <= MFP_UART_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= shift >> 1;
              tx      <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        MFP_UART_STOP: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (pop) begin
              shift <= fifo_rd_data;
              tx    <= 1'b0;
              state <= MFP_UART_START;
            end else begin
              tx    <= 1'b1;
              state <= MFP_UART_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= MFP_UART_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
